// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 24-hour BCD clock with keypad entry and NUM_ALARMS
// independent alarm channels. All displays are ASCII digits.
// Optional feature: define MULTI_ALARM_SNOOZE_EN to enable the snooze input.
// Without it the snooze input is ignored and no snooze state exists.
module multi_alarm_clock #(
    parameter int NUM_ALARMS        = 4,
    parameter int CLK_PER_SEC       = 256,
    parameter int ALARM_TIMEOUT_SEC = 10,
    parameter int KEY_TIMEOUT_SEC   = 10
) (
    input  logic                                                 clock,
    input  logic                                                 reset,
    input  logic                                                 fastwatch,
    input  logic [3:0]                                           key,
    input  logic                                                 time_button,
    input  logic                                                 alarm_button,
    input  logic [((NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1)-1:0] alarm_sel,
    input  logic                                                 stop_alarm,
    input  logic                                                 snooze,
    output logic [7:0]                                           ms_hour,
    output logic [7:0]                                           ls_hour,
    output logic [7:0]                                           ms_minute,
    output logic [7:0]                                           ls_minute,
    output logic [NUM_ALARMS-1:0]                                alarm_active,
    output logic                                                 alarm_sound
);

    localparam int SEL_W  = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int SEL_W1 = SEL_W + 1;
    localparam int TICK_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam int ATO_W  = $clog2(ALARM_TIMEOUT_SEC + 1);
    localparam int KTO_W  = $clog2(KEY_TIMEOUT_SEC + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_PER_SEC - 1);
    localparam logic [ATO_W-1:0]  ATO_LAST  = ATO_W'(ALARM_TIMEOUT_SEC - 1);
    localparam logic [KTO_W-1:0]  KTO_LAST  = KTO_W'(KEY_TIMEOUT_SEC - 1);
    localparam logic [SEL_W:0]    SEL_LIMIT = SEL_W1'(NUM_ALARMS);

    typedef enum logic [0:0] {
        SHOW_TIME = 1'b0,
        KEY_ENTRY = 1'b1
    } state_t;

    // Times are packed BCD {hour tens, hour ones, minute tens, minute ones}.
    function automatic logic [15:0] incr_minute(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                r[7:4] = t[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if ((t[15:12] == 4'd2) && (t[11:8] == 4'd3)) begin
                    r[15:8] = 8'h00;
                end else if (t[11:8] == 4'd9) begin
                    r[15:12] = t[15:12] + 4'd1;
                    r[11:8]  = 4'd0;
                end else begin
                    r[11:8] = t[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic time_valid(input logic [15:0] t);
        return (t[15:12] <= 4'd2) && (t[11:8] <= 4'd9) &&
               (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9) &&
               ((t[15:12] != 4'd2) || (t[11:8] <= 4'd3));
    endfunction

    state_t                state_r;
    logic [15:0]           entry_buf_r;
    logic [KTO_W-1:0]      key_tmr_r;
    logic                  key_prev_digit_r;
    logic [TICK_W-1:0]     tick_cnt_r;
    logic [5:0]            sec_r;
    logic [15:0]           time_r;
    logic                  adv_r;
    logic [15:0]           alarm_time_r [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] alarm_en_r;
    logic [NUM_ALARMS-1:0] alarm_active_r;
    logic                  alarm_sound_r;
    logic [ATO_W-1:0]      atmr_r [NUM_ALARMS];
    logic [7:0]            ms_hour_r;
    logic [7:0]            ls_hour_r;
    logic [7:0]            ms_minute_r;
    logic [7:0]            ls_minute_r;

    logic                  tick_s;
    logic                  key_digit_s;
    logic                  digit_edge_s;
    logic                  in_entry_s;
    logic                  buf_ok_s;
    logic                  sel_ok_s;
    logic                  load_time_s;
    logic                  load_alarm_s;
    logic                  snooze_s;
    logic [15:0]           disp_src_s;
    logic [15:0]           target_s [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] fire_s;
    logic [NUM_ALARMS-1:0] act_nx_s;
    logic [ATO_W-1:0]      atmr_nx_s [NUM_ALARMS];

    assign tick_s       = (tick_cnt_r == TICK_LAST);
    assign key_digit_s  = (key <= 4'd9);
    assign digit_edge_s = key_digit_s && !key_prev_digit_r;
    assign in_entry_s   = (state_r == KEY_ENTRY);
    assign buf_ok_s     = time_valid(entry_buf_r);
    assign sel_ok_s     = ({1'b0, alarm_sel} < SEL_LIMIT);
    // time_button wins when both buttons arrive together.
    assign load_time_s  = in_entry_s && time_button && buf_ok_s;
    assign load_alarm_s = in_entry_s && !time_button && alarm_button && buf_ok_s && sel_ok_s;
    assign disp_src_s   = in_entry_s ? entry_buf_r : time_r;

    // Keypad entry FSM: digit capture on key edge, button handling, entry timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r          <= SHOW_TIME;
            entry_buf_r      <= 16'h0000;
            key_tmr_r        <= {KTO_W{1'b0}};
            key_prev_digit_r <= 1'b0;
        end else begin
            key_prev_digit_r <= key_digit_s;
            case (state_r)
                SHOW_TIME: begin
                    if (digit_edge_s) begin
                        state_r     <= KEY_ENTRY;
                        entry_buf_r <= {12'h000, key};
                        key_tmr_r   <= {KTO_W{1'b0}};
                    end
                end
                KEY_ENTRY: begin
                    if (time_button || alarm_button) begin
                        state_r <= SHOW_TIME;
                    end else if (digit_edge_s) begin
                        entry_buf_r <= {entry_buf_r[11:0], key};
                        key_tmr_r   <= {KTO_W{1'b0}};
                    end else if (tick_s) begin
                        if (key_tmr_r == KTO_LAST) begin
                            state_r <= SHOW_TIME;
                        end else begin
                            key_tmr_r <= key_tmr_r + 1'b1;
                        end
                    end
                end
                default: state_r <= SHOW_TIME;
            endcase
        end
    end

    // Timekeeping: tick divider, seconds, minute advance, and time load.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            sec_r      <= 6'd0;
            time_r     <= 16'h0000;
            adv_r      <= 1'b0;
        end else if (load_time_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            sec_r      <= 6'd0;
            time_r     <= entry_buf_r;
            adv_r      <= 1'b0;
        end else begin
            adv_r      <= 1'b0;
            tick_cnt_r <= tick_s ? {TICK_W{1'b0}} : tick_cnt_r + 1'b1;
            if (tick_s) begin
                if (fastwatch || (sec_r == 6'd59)) begin
                    sec_r  <= 6'd0;
                    time_r <= incr_minute(time_r);
                    adv_r  <= 1'b1;
                end else begin
                    sec_r <= sec_r + 6'd1;
                end
            end else if (fastwatch) begin
                sec_r <= 6'd0;
            end
        end
    end

    // Alarm time and enable storage, written from a valid keypad entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            alarm_time_r <= '{default: 16'h0000};
            alarm_en_r   <= {NUM_ALARMS{1'b0}};
        end else if (load_alarm_s) begin
            alarm_time_r[alarm_sel] <= entry_buf_r;
            alarm_en_r[alarm_sel]   <= 1'b1;
        end
    end

`ifdef MULTI_ALARM_SNOOZE_EN
    logic [NUM_ALARMS-1:0] snz_pend_r;
    logic [15:0]           snz_time_r [NUM_ALARMS];

    function automatic logic [15:0] add_five(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        for (int k = 0; k < 5; k++) begin
            r = incr_minute(r);
        end
        return r;
    endfunction

    assign snooze_s = snooze;

    // A pending snooze temporarily replaces the channel's compare time.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            target_s[i] = alarm_time_r[i];
            if (snz_pend_r[i]) begin
                target_s[i] = snz_time_r[i];
            end else begin
                target_s[i] = alarm_time_r[i];
            end
        end
    end

    // Snooze bookkeeping: arm on snooze, drop after the snoozed firing or a reload.
    always_ff @(posedge clock) begin
        if (reset) begin
            snz_pend_r <= {NUM_ALARMS{1'b0}};
            snz_time_r <= '{default: 16'h0000};
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (load_alarm_s && (alarm_sel == SEL_W'(i))) begin
                    snz_pend_r[i] <= 1'b0;
                end else if (snooze_s && alarm_active_r[i]) begin
                    snz_pend_r[i] <= 1'b1;
                    snz_time_r[i] <= add_five(target_s[i]);
                end else if (fire_s[i]) begin
                    snz_pend_r[i] <= 1'b0;
                end
            end
        end
    end
`else
    logic unused_snooze_s;

    assign snooze_s        = 1'b0;
    assign unused_snooze_s = snooze;

    // Without snooze every channel compares against its stored alarm time.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            target_s[i] = alarm_time_r[i];
        end
    end
`endif

    // A channel fires only on a counting advance, never on a time load.
    always_comb begin
        fire_s = {NUM_ALARMS{1'b0}};
        for (int i = 0; i < NUM_ALARMS; i++) begin
            fire_s[i] = adv_r && alarm_en_r[i] && (time_r == target_s[i]);
        end
    end

    // Next alarm_active state: timeout, global stop/snooze clear, new firings.
    always_comb begin
        act_nx_s = alarm_active_r;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            atmr_nx_s[i] = atmr_r[i];
            if (alarm_active_r[i] && tick_s) begin
                if (atmr_r[i] == ATO_LAST) begin
                    act_nx_s[i] = 1'b0;
                end else begin
                    atmr_nx_s[i] = atmr_r[i] + 1'b1;
                end
            end else begin
                atmr_nx_s[i] = atmr_r[i];
            end
        end
        if (stop_alarm || snooze_s) begin
            act_nx_s = {NUM_ALARMS{1'b0}};
        end else begin
            act_nx_s = act_nx_s;
        end
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (fire_s[i]) begin
                act_nx_s[i]  = 1'b1;
                atmr_nx_s[i] = {ATO_W{1'b0}};
            end else begin
                act_nx_s[i] = act_nx_s[i];
            end
        end
    end

    // Alarm state registers; alarm_sound is registered from the same next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            alarm_active_r <= {NUM_ALARMS{1'b0}};
            alarm_sound_r  <= 1'b0;
            atmr_r         <= '{default: {ATO_W{1'b0}}};
        end else begin
            alarm_active_r <= act_nx_s;
            alarm_sound_r  <= |act_nx_s;
            atmr_r         <= atmr_nx_s;
        end
    end

    // Registered ASCII displays: entry buffer while typing, otherwise the time.
    always_ff @(posedge clock) begin
        if (reset) begin
            ms_hour_r   <= 8'h30;
            ls_hour_r   <= 8'h30;
            ms_minute_r <= 8'h30;
            ls_minute_r <= 8'h30;
        end else begin
            ms_hour_r   <= 8'h30 + {4'h0, disp_src_s[15:12]};
            ls_hour_r   <= 8'h30 + {4'h0, disp_src_s[11:8]};
            ms_minute_r <= 8'h30 + {4'h0, disp_src_s[7:4]};
            ls_minute_r <= 8'h30 + {4'h0, disp_src_s[3:0]};
        end
    end

    assign ms_hour      = ms_hour_r;
    assign ls_hour      = ls_hour_r;
    assign ms_minute    = ms_minute_r;
    assign ls_minute    = ls_minute_r;
    assign alarm_active = alarm_active_r;
    assign alarm_sound  = alarm_sound_r;

endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 Parameter NUM_ALARMS, default 4: number of independent alarm channels, 1..8.
REQ-002 Parameter CLK_PER_SEC, default 256: clock cycles per one-second tick.
REQ-003 Parameter ALARM_TIMEOUT_SEC, default 10: seconds an alarm sounds before auto-clear.
REQ-004 Parameter KEY_TIMEOUT_SEC, default 10: seconds of key inactivity before entry is abandoned.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clock  in  1: sole clock, all state on rising edge.
REQ-007 reset  in  1: synchronous, active-high reset.
REQ-008 fastwatch  in  1: 1 = minute advances every tick (test speed-up).
REQ-009 key  in  4: 0-9 digit pressed, 10 = no key, 11-15 treated as no key.
REQ-010 time_button  in  1: load entered digits as current time.
REQ-011 alarm_button  in  1: load entered digits into the selected alarm.
REQ-012 alarm_sel  in  max(1,clog2(NUM_ALARMS)): alarm channel targeted by alarm_button.
REQ-013 stop_alarm  in  1: silence all sounding alarms.
REQ-014 snooze  in  1: snooze request (active only with SNOOZE_EN).
REQ-015 ms_hour, ls_hour, ms_minute, ls_minute  out  8 each: ASCII digit (8'h30 + value).
REQ-016 alarm_active  out  NUM_ALARMS: per-channel sounding flag.
REQ-017 alarm_sound  out  1: OR of alarm_active.

Function
REQ-018 Tick counter SHALL count 0..CLK_PER_SEC-1 and pulse one-cycle tick at wrap.
REQ-019 Normal mode: minute SHALL advance every 60 ticks; fastwatch=1: every tick, seconds counter held 0.
REQ-020 Time SHALL wrap 09:59->10:00, 23:59->00:00; hours 00-23, minutes 00-59.
REQ-021 Key digit SHALL be captured once on transition from no-key to 0-9; held keys do not repeat.
REQ-022 Captured digit SHALL shift into a 4-digit buffer from ls_minute side, older digits shifting left; buffer cleared to 0000 on entry start.
REQ-023 FSM states SHOW_TIME, KEY_ENTRY; first digit moves SHOW_TIME->KEY_ENTRY.
REQ-024 In KEY_ENTRY displays SHALL show the buffer; in SHOW_TIME the current time.
REQ-025 time_button in KEY_ENTRY with valid buffer (HH<=23, MM<=59) SHALL load time, clear seconds and tick counter, return SHOW_TIME next cycle.
REQ-026 alarm_button in KEY_ENTRY with valid buffer SHALL load alarm[alarm_sel] and set its enable, return SHOW_TIME; alarm_sel >= NUM_ALARMS ignored.
REQ-027 Invalid buffer on either button SHALL discard entry, return SHOW_TIME, leave time/alarms unchanged.
REQ-028 Buttons in SHOW_TIME SHALL have no effect.
REQ-029 Both buttons same cycle: time_button wins; button and digit edge same cycle: button acts, digit ignored.
REQ-030 KEY_TIMEOUT_SEC ticks without a captured digit in KEY_ENTRY SHALL discard entry, return SHOW_TIME.
REQ-031 On the cycle time changes to a value equal to an enabled alarm, that alarm_active bit SHALL set next cycle; multiple channels may set together.
REQ-032 Time load equal to an alarm SHALL NOT trigger it (only counting advances trigger).
REQ-033 stop_alarm SHALL clear all alarm_active next cycle; enables unchanged.
REQ-034 Each active channel SHALL auto-clear after ALARM_TIMEOUT_SEC ticks from its setting.
REQ-035 Time keeps counting during KEY_ENTRY and while alarms sound.

Reset
REQ-036 reset SHALL set time 00:00, seconds 0, tick counter 0, state SHOW_TIME, buffer 0000, all alarms 00:00 disabled, alarm_active 0.
REQ-037 Outputs after reset: all four displays 8'h30, alarm_sound 0; reset mid-entry or mid-alarm obeys the same.

Configuration
REQ-038 Macro MULTI_ALARM_SNOOZE_EN defined: snooze clears alarm_active and re-arms each cleared channel to fire 5 minutes later (wrap past 23:59) once, then original alarm time restored.
REQ-039 Macro undefined: snooze input ignored, no snooze storage synthesised.

Verification
REQ-040 Keys 1,1,2,3 (each 3 cycles then 10), time_button -> displays 31 31 32 33; fastwatch=1, 7*256 cycles later 31 31 33 30.
REQ-041 Time 11:23, alarm_sel=2 entry 1130 + alarm_button, fastwatch -> alarm_active=4'b0100 at 11:30, alarm_sound=1, clears after 10*256 cycles.
REQ-042 Time 23:59 fastwatch=1 -> one tick later displays 30 30 30 30.
REQ-043 Entry 2460 + time_button -> time unchanged, state SHOW_TIME; entry 12 then 10*256 idle cycles -> entry discarded.
REQ-044 Alarms 0 and 3 both 08:00, time 07:59 -> both bits set together; stop_alarm -> 0 next cycle.
REQ-045 MULTI_ALARM_SNOOZE_EN: alarm at 06:00, snooze -> clears, re-fires 06:05; without macro snooze no effect.
